// File: rtl/data_memory_dump_unit_if.sv
// -----------------------------------------------------------------------------
// data_memory_dump_unit_if
//
// Groups the signals of the post-halt data-memory dump unit: the halt request
// and core hold, the synchronous data-memory read port and the {address, data}
// output stream with its running checksum and done flag.
//
//   halt            : EBREAK detected in decode (environment -> unit)
//   core_hold       : freezes the core pipeline (unit -> core)
//   mem_read_enable : data-memory read strobe (unit -> memory)
//   mem_address     : byte address of the word read, 4-aligned (unit -> memory)
//   mem_data        : read data, valid the cycle after the strobe (memory -> unit)
//   out_valid       : stream beat valid (unit -> consumer)
//   out_ready       : consumer ready (consumer -> unit)
//   out_address     : byte address of the beat (unit -> consumer)
//   out_data        : word of the beat (unit -> consumer)
//   checksum        : XOR of all words transferred so far (unit -> consumer)
//   done            : sticky, whole memory streamed (unit -> consumer)
//
// The master modport is the dump unit; the slave modport is its environment.
// -----------------------------------------------------------------------------
interface data_memory_dump_unit_if #(
   parameter int ADDRESS_WIDTH = 12
);
   logic                     halt;
   logic                     core_hold;
   logic                     mem_read_enable;
   logic [ADDRESS_WIDTH-1:0] mem_address;
   logic [31:0]              mem_data;
   logic                     out_valid;
   logic                     out_ready;
   logic [ADDRESS_WIDTH-1:0] out_address;
   logic [31:0]              out_data;
   logic [31:0]              checksum;
   logic                     done;

   modport master (
      input  halt, mem_data, out_ready,
      output core_hold, mem_read_enable, mem_address,
             out_valid, out_address, out_data, checksum, done
   );

   modport slave (
      output halt, mem_data, out_ready,
      input  core_hold, mem_read_enable, mem_address,
             out_valid, out_address, out_data, checksum, done
   );
endinterface

// File: rtl/data_memory_dump_unit.sv
// -----------------------------------------------------------------------------
// data_memory_dump_unit
//
// Post-halt data-memory streamer. When halt is seen in IDLE the core is held,
// the whole data memory is read word by word through a 1-cycle synchronous
// read port, and each word is offered as an {address, data} beat on a
// valid/ready stream. A running XOR checksum of the transferred words is kept.
// After the last word the unit parks in DONE until reset.
//
// Ports:
//   CLK   : single clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : data_memory_dump_unit_if.master (halt/hold, memory port, stream)
//
// Per word the sequence is READ (strobe), LATCH (capture read data), SEND
// (hold beat until accepted), so best case is one beat every three cycles.
// -----------------------------------------------------------------------------
module data_memory_dump_unit #(
   parameter int ADDRESS_WIDTH = 12
) (
   input  logic                   CLK,
   input  logic                   reset,
   data_memory_dump_unit_if.master bus
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_LATCH,
      ST_SEND,
      ST_DONE
   } state_e;

   // Byte address of the final word; compared before incrementing so the
   // pointer never wraps back to 0.
   localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = {{(ADDRESS_WIDTH-2){1'b1}}, 2'b00};
   localparam logic [ADDRESS_WIDTH-1:0] WORD_STEP = ADDRESS_WIDTH'(4);

   state_e                   state_q,       state_d;
   logic [ADDRESS_WIDTH-1:0] ptr_q,         ptr_d;
   logic                     core_hold_q,   core_hold_d;
   logic                     out_valid_q,   out_valid_d;
   logic [ADDRESS_WIDTH-1:0] out_address_q, out_address_d;
   logic [31:0]              out_data_q,    out_data_d;
   logic [31:0]              checksum_q,    checksum_d;
   logic                     done_q,        done_d;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the values from before the edge, independent of statement order.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         ptr_q         <= '0;
         core_hold_q   <= 1'b0;
         out_valid_q   <= 1'b0;
         out_address_q <= '0;
         out_data_q    <= '0;
         checksum_q    <= '0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         core_hold_q   <= core_hold_d;
         out_valid_q   <= out_valid_d;
         out_address_q <= out_address_d;
         out_data_q    <= out_data_d;
         checksum_q    <= checksum_d;
         done_q        <= done_d;
      end
   end

   always_comb begin
      // NOTE: every signal gets a hold-value default first so no path through
      // the case statement leaves one unassigned and infers a latch.
      state_d       = state_q;
      ptr_d         = ptr_q;
      core_hold_d   = core_hold_q;
      out_valid_d   = out_valid_q;
      out_address_d = out_address_q;
      out_data_d    = out_data_q;
      checksum_d    = checksum_q;
      done_d        = done_q;

      unique case (state_q)
         ST_IDLE: begin
            // halt is only looked at here; re-assertion later is ignored.
            if (bus.halt) begin
               state_d     = ST_READ;
               core_hold_d = 1'b1;
               ptr_d       = '0;
            end
         end
         ST_READ: begin
            state_d = ST_LATCH;
         end
         ST_LATCH: begin
            // Read data from the strobe issued in READ is valid now.
            out_data_d    = bus.mem_data;
            out_address_d = ptr_q;
            out_valid_d   = 1'b1;
            state_d       = ST_SEND;
         end
         ST_SEND: begin
            if (out_valid_q && bus.out_ready) begin
               checksum_d  = checksum_q ^ out_data_q;
               out_valid_d = 1'b0;
               if (ptr_q == LAST_ADDR) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  ptr_d   = ptr_q + WORD_STEP;
                  state_d = ST_READ;
               end
            end
         end
         ST_DONE: begin
            // Terminal: only reset leaves this state.
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Read strobe and address are decoded straight from the state so reset
   // clears them without waiting for an edge.
   assign bus.mem_read_enable = (state_q == ST_READ);
   assign bus.mem_address     = (state_q == ST_READ) ? ptr_q : '0;

   assign bus.core_hold   = core_hold_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_address = out_address_q;
   assign bus.out_data    = out_data_q;
   assign bus.checksum    = checksum_q;
   assign bus.done        = done_q;

endmodule

// File: tb/tb_data_memory_dump_unit.sv
// -----------------------------------------------------------------------------
// tb_data_memory_dump_unit
//
// Two instances: a 4-word unit (ADDRESS_WIDTH=4) for directed scenarios and a
// 1024-word unit (ADDRESS_WIDTH=12) driven with random out_ready. Expected
// beats are queued from the memory contents when halt is issued; a monitor
// per instance pops and compares on every accepted beat, tracks the expected
// checksum, and checks beat stability while stalled.
// -----------------------------------------------------------------------------
module tb_data_memory_dump_unit;

   localparam int AW_S    = 4;
   localparam int AW_B    = 12;
   localparam int WORDS_S = 2 ** (AW_S - 2);
   localparam int WORDS_B = 2 ** (AW_B - 2);

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } beat_t;

   logic CLK   = 1'b0;
   logic reset = 1'b0;
   always #5 CLK = ~CLK;

   data_memory_dump_unit_if #(.ADDRESS_WIDTH(AW_S)) bus_s ();
   data_memory_dump_unit_if #(.ADDRESS_WIDTH(AW_B)) bus_b ();

   data_memory_dump_unit #(.ADDRESS_WIDTH(AW_S)) dut_s (
      .CLK   (CLK),
      .reset (reset),
      .bus   (bus_s.master)
   );

   data_memory_dump_unit #(.ADDRESS_WIDTH(AW_B)) dut_b (
      .CLK   (CLK),
      .reset (reset),
      .bus   (bus_b.master)
   );

   // Synchronous-read data memories.
   logic [31:0] mem_s [WORDS_S];
   logic [31:0] mem_b [WORDS_B];

   always @(posedge CLK) begin
      if (bus_s.mem_read_enable) bus_s.mem_data <= mem_s[bus_s.mem_address[AW_S-1:2]];
      if (bus_b.mem_read_enable) bus_b.mem_data <= mem_b[bus_b.mem_address[AW_B-1:2]];
   end

   // Scoreboard state.
   beat_t       exp_q_s[$];
   beat_t       exp_q_b[$];
   logic [31:0] exp_ck     [2];
   int          beats      [2];
   logic        stall_prev [2];
   logic [31:0] prev_addr  [2];
   logic [31:0] prev_data  [2];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act !== want) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, want);
      end
   endtask

   // Model: a dump emits every word in ascending address order.
   task automatic push_expected_s();
      for (int i = 0; i < WORDS_S; i++) exp_q_s.push_back('{addr: 32'(i * 4), data: mem_s[i]});
   endtask

   task automatic push_expected_b();
      for (int i = 0; i < WORDS_B; i++) exp_q_b.push_back('{addr: 32'(i * 4), data: mem_b[i]});
   endtask

   task automatic monitor_sample(input int id, input string tag, input logic rst_v,
                                 input logic valid, input logic ready, input logic re,
                                 input logic [31:0] maddr, input logic [31:0] oaddr,
                                 input logic [31:0] odata, input logic [31:0] cksum);
      beat_t want;
      bit    have;
      if (!rst_v) begin
         exp_ck[id]     = '0;
         stall_prev[id] = 1'b0;
         return;
      end
      if (re) check($sformatf("%s_memaddr_align", tag), {30'd0, maddr[1:0]}, 32'd0);
      else    check($sformatf("%s_memaddr_idle", tag), maddr, 32'd0);
      check($sformatf("%s_checksum", tag), cksum, exp_ck[id]);
      if (stall_prev[id]) begin
         check($sformatf("%s_stall_valid", tag), 32'(valid), 32'd1);
         check($sformatf("%s_stall_addr", tag), oaddr, prev_addr[id]);
         check($sformatf("%s_stall_data", tag), odata, prev_data[id]);
      end
      if (valid && ready) begin
         have = 1'b0;
         if (id == 0) begin
            if (exp_q_s.size() > 0) begin want = exp_q_s.pop_front(); have = 1'b1; end
         end else begin
            if (exp_q_b.size() > 0) begin want = exp_q_b.pop_front(); have = 1'b1; end
         end
         if (!have) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_unexpected_beat: got addr 0x%08h data 0x%08h expected no beat", tag, oaddr, odata);
         end else begin
            check($sformatf("%s_beat_addr", tag), oaddr, want.addr);
            check($sformatf("%s_beat_data", tag), odata, want.data);
            exp_ck[id] = exp_ck[id] ^ want.data;
         end
         beats[id]++;
      end
      stall_prev[id] = valid && !ready;
      prev_addr[id]  = oaddr;
      prev_data[id]  = odata;
   endtask

   always @(negedge CLK)
      monitor_sample(0, "s", reset, bus_s.out_valid, bus_s.out_ready, bus_s.mem_read_enable,
                     32'(bus_s.mem_address), 32'(bus_s.out_address), bus_s.out_data, bus_s.checksum);

   always @(negedge CLK)
      monitor_sample(1, "b", reset, bus_b.out_valid, bus_b.out_ready, bus_b.mem_read_enable,
                     32'(bus_b.mem_address), 32'(bus_b.out_address), bus_b.out_data, bus_b.checksum);

   task automatic do_reset();
      @(negedge CLK);
      reset = 1'b0;
      exp_q_s.delete();
      exp_q_b.delete();
      repeat (2) @(negedge CLK);
      reset = 1'b1;
   endtask

   task automatic wait_done_s(input int budget, input string name);
      int n = 0;
      while (bus_s.done !== 1'b1 && n < budget) begin
         @(posedge CLK); #1;
         n++;
      end
      check({name, "_done"}, 32'(bus_s.done), 32'd1);
   endtask

   task automatic pulse_halt_s();
      @(posedge CLK); #1;
      bus_s.halt = 1'b1;
      push_expected_s();
      @(posedge CLK); #1;
      bus_s.halt = 1'b0;
   endtask

   task automatic check_parked_s(input string name);
      check({name, "_done"},      32'(bus_s.done),            32'd1);
      check({name, "_core_hold"}, 32'(bus_s.core_hold),       32'd1);
      check({name, "_valid"},     32'(bus_s.out_valid),       32'd0);
      check({name, "_read_en"},   32'(bus_s.mem_read_enable), 32'd0);
      check({name, "_checksum"},  bus_s.checksum,             32'hFFFF_FFFF);
   endtask

   initial begin
      int b0;
      int n;

      bus_s.halt      = 1'b0;
      bus_s.out_ready = 1'b0;
      bus_b.halt      = 1'b0;
      bus_b.out_ready = 1'b0;
      mem_s = '{32'h1111_1111, 32'h2222_2222, 32'h4444_4444, 32'h8888_8888};
      for (int i = 0; i < WORDS_B; i++) mem_b[i] = 32'(i);

      // Reset state.
      reset = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      check("rst_core_hold", 32'(bus_s.core_hold),       32'd0);
      check("rst_read_en",   32'(bus_s.mem_read_enable), 32'd0);
      check("rst_mem_addr",  32'(bus_s.mem_address),     32'd0);
      check("rst_valid",     32'(bus_s.out_valid),       32'd0);
      check("rst_out_addr",  32'(bus_s.out_address),     32'd0);
      check("rst_out_data",  bus_s.out_data,             32'd0);
      check("rst_checksum",  bus_s.checksum,             32'd0);
      check("rst_done",      32'(bus_s.done),            32'd0);
      check("rst_big_outs",  {bus_b.checksum[27:0], bus_b.core_hold, bus_b.mem_read_enable,
                              bus_b.out_valid, bus_b.done}, 32'd0);
      @(negedge CLK);
      reset = 1'b1;

      // Idle with halt low: nothing moves.
      for (int i = 0; i < 100; i++) begin
         @(posedge CLK); #1;
         check("idle_s", {28'd0, bus_s.mem_read_enable, bus_s.out_valid, bus_s.core_hold, bus_s.done}, 32'd0);
         check("idle_b", {28'd0, bus_b.mem_read_enable, bus_b.out_valid, bus_b.core_hold, bus_b.done}, 32'd0);
      end

      // Basic dump, ready tied high, single-cycle halt pulse, latency check.
      bus_s.out_ready = 1'b1;
      b0 = beats[0];
      @(posedge CLK); #1;
      bus_s.halt = 1'b1;
      push_expected_s();
      @(posedge CLK); #1;               // halt sampled on this edge
      bus_s.halt = 1'b0;
      check("t1_core_hold_e0", 32'(bus_s.core_hold),       32'd1);
      check("t1_read_en_e0",   32'(bus_s.mem_read_enable), 32'd1);
      check("t1_valid_e0",     32'(bus_s.out_valid),       32'd0);
      @(posedge CLK); #1;
      check("t1_valid_e1",     32'(bus_s.out_valid),       32'd0);
      @(posedge CLK); #1;               // third edge counting the halt edge
      check("t1_valid_e2",     32'(bus_s.out_valid),       32'd1);
      check("t1_first_addr",   32'(bus_s.out_address),     32'd0);
      wait_done_s(50, "t1");
      check("t1_beats",    32'(beats[0] - b0),   32'd4);
      check("t1_checksum", bus_s.checksum,       32'hFFFF_FFFF);
      check("t1_q_empty",  32'(exp_q_s.size()),  32'd0);

      // Backpressure for 5 cycles on the beat at address 0x8.
      do_reset();
      bus_s.out_ready = 1'b1;
      b0 = beats[0];
      pulse_halt_s();
      n = 0;
      while (!(bus_s.mem_read_enable && bus_s.mem_address == 4'h8) && n < 30) begin
         @(posedge CLK); #1;
         n++;
      end
      check("t2_reach_beat2", 32'(bus_s.mem_address), 32'h8);
      bus_s.out_ready = 1'b0;
      n = 0;
      while (!bus_s.out_valid && n < 10) begin
         @(posedge CLK); #1;
         n++;
      end
      for (int k = 0; k < 5; k++) begin
         check("t2_hold_valid", 32'(bus_s.out_valid),   32'd1);
         check("t2_hold_addr",  32'(bus_s.out_address), 32'h8);
         check("t2_hold_data",  bus_s.out_data,         32'h4444_4444);
         if (k < 4) begin @(posedge CLK); #1; end
      end
      bus_s.out_ready = 1'b1;
      wait_done_s(50, "t2");
      check("t2_beats",    32'(beats[0] - b0), 32'd4);
      check("t2_checksum", bus_s.checksum,     32'hFFFF_FFFF);

      // Halt held high throughout, then re-pulsed in DONE.
      do_reset();
      b0 = beats[0];
      @(posedge CLK); #1;
      bus_s.halt = 1'b1;
      push_expected_s();
      wait_done_s(50, "t3");
      for (int k = 0; k < 20; k++) begin
         @(posedge CLK); #1;
         check_parked_s("t3_held");
      end
      bus_s.halt = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      bus_s.halt = 1'b1;
      @(posedge CLK); #1;
      bus_s.halt = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(posedge CLK); #1;
         check_parked_s("t3_repulse");
      end
      check("t3_beats", 32'(beats[0] - b0), 32'd4);

      // Asynchronous reset mid-cycle during the SEND of the beat at 0x4.
      do_reset();
      bus_s.out_ready = 1'b1;
      pulse_halt_s();
      n = 0;
      while (!(bus_s.mem_read_enable && bus_s.mem_address == 4'h4) && n < 30) begin
         @(posedge CLK); #1;
         n++;
      end
      bus_s.out_ready = 1'b0;
      n = 0;
      while (!bus_s.out_valid && n < 10) begin
         @(posedge CLK); #1;
         n++;
      end
      check("t4_in_send",     32'(bus_s.out_valid), 32'd1);
      check("t4_pre_ck",      bus_s.checksum,       32'h1111_1111);
      @(negedge CLK);
      #2;
      reset = 1'b0;
      exp_q_s.delete();
      #1;
      check("t4_core_hold", 32'(bus_s.core_hold),       32'd0);
      check("t4_read_en",   32'(bus_s.mem_read_enable), 32'd0);
      check("t4_mem_addr",  32'(bus_s.mem_address),     32'd0);
      check("t4_valid",     32'(bus_s.out_valid),       32'd0);
      check("t4_out_addr",  32'(bus_s.out_address),     32'd0);
      check("t4_out_data",  bus_s.out_data,             32'd0);
      check("t4_checksum",  bus_s.checksum,             32'd0);
      check("t4_done",      32'(bus_s.done),            32'd0);
      repeat (2) @(negedge CLK);
      reset = 1'b1;
      bus_s.out_ready = 1'b1;
      b0 = beats[0];
      pulse_halt_s();
      n = 0;
      while (!bus_s.out_valid && n < 10) begin
         @(posedge CLK); #1;
         n++;
      end
      check("t4_restart_addr", 32'(bus_s.out_address), 32'd0);
      check("t4_restart_ck",   bus_s.checksum,         32'd0);
      wait_done_s(50, "t4");
      check("t4_beats",    32'(beats[0] - b0), 32'd4);
      check("t4_final_ck", bus_s.checksum,     32'hFFFF_FFFF);

      // Full 1024-word dump with random backpressure.
      b0 = beats[1];
      @(posedge CLK); #1;
      bus_b.halt = 1'b1;
      push_expected_b();
      @(posedge CLK); #1;
      bus_b.halt = 1'b0;
      n = 0;
      while (bus_b.done !== 1'b1 && n < 30000) begin
         @(posedge CLK); #1;
         bus_b.out_ready = 1'($urandom_range(0, 1));
         n++;
      end
      check("t5_done", 32'(bus_b.done), 32'd1);
      for (int k = 0; k < 20; k++) begin
         @(posedge CLK); #1;
         bus_b.out_ready = 1'($urandom_range(0, 1));
      end
      check("t5_beats",     32'(beats[1] - b0),  32'd1024);
      check("t5_checksum",  bus_b.checksum,      32'd0);
      check("t5_q_empty",   32'(exp_q_b.size()), 32'd0);
      check("t5_core_hold", 32'(bus_b.core_hold), 32'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
